axis_stall_watchdog: RTL and testbench
======================================

Name: axis_stall_watchdog

Overview:
- Deadlock-qualification stage that consumes the per-channel block and idle signals gathered from the HLS kernel (e.g. the sobel_rgb_axis row/col pipeline).
- Declares a deadlock only after the stall condition has persisted for a programmable number of cycles.
- On declaring, latches which channels were stuck and counts stall duration.
- Output feeds the testbench deadlock trigger and report logic.

Parameters:
NUM_CH, 2, number of monitored channels (AXIS ports / sub-instances)
THRESHOLD, 16, consecutive stalled cycles required to declare deadlock; legal range 2 to 2^CNT_W-1
CNT_W, 16, width of the stall counter

Ports:
kernel_monitor_clock  in  1  monitor clock
kernel_monitor_reset_n  in  1  asynchronous active-low reset
enable  in  1  watchdog armed
clear  in  1  synchronous clear of latched deadlock and counters
axis_block_sigs  in  NUM_CH  1 = AXIS port i is blocked (blk_n low)
inst_block_sigs  in  NUM_CH  1 = sub-instance i is blocked on an internal channel
inst_idle_sigs  in  NUM_CH  1 = sub-instance i is idle
block  out  1  latched deadlock flag
block_pulse  out  1  single-cycle strobe on deadlock declaration
block_chan  out  NUM_CH  snapshot of the stuck vector at declaration
stall_cycles  out  CNT_W  saturating count of stalled cycles in the current episode
state  out  2  0=WATCH, 1=SUSPECT, 2=DEADLOCK

Behaviour:
- Reset is asynchronous and active-low.
  - While kernel_monitor_reset_n=0, all outputs are 0 and state is WATCH.
  - Reset applies immediately, including mid-SUSPECT or mid-DEADLOCK.
- Combinational terms:
  - stuck[i] = axis_block_sigs[i] | inst_block_sigs[i].
  - quiet[i] = stuck[i] | inst_idle_sigs[i].
  - raw = (|stuck) & (&quiet). raw means at least one channel is stuck and none is doing work.
- All inputs are sampled on the rising clock edge. There is no input registering, so latency is measured from sampled edges.
- Priority at each edge: clear > state logic. clear=1 forces state WATCH, stall_cycles=0, block=0, block_chan=0, block_pulse=0 on the next edge, in any state.
- WATCH:
  - enable=1 and raw=1: go to SUSPECT, stall_cycles=1.
  - Otherwise stay, stall_cycles=0.
- SUSPECT:
  - enable=0 or raw=0: go to WATCH, stall_cycles=0.
  - raw=1 and stall_cycles==THRESHOLD-1: go to DEADLOCK, stall_cycles=THRESHOLD, block=1, block_pulse=1, block_chan=stuck as sampled at this edge.
  - Otherwise stall_cycles+1.
- Net latency: block rises at the edge on which raw has been sampled 1 for THRESHOLD consecutive edges.
- DEADLOCK:
  - Sticky. Ignores enable and raw; exits only via clear or reset.
  - stall_cycles increments on each edge with raw=1 and holds when raw=0.
  - block_chan holds its value.
  - block_pulse returns to 0 one edge after assertion.
- stall_cycles saturates at 2^CNT_W-1 and never wraps.
- block_pulse is high for exactly one cycle per declaration. It can re-fire only after clear and requalification.
- Boundary cases:
  - raw toggling 1,0,1 restarts qualification from 1.
  - clear and a qualifying raw on the same edge: clear wins, state WATCH.
  - raw=1 on the first edge after clear deassertion: SUSPECT begins on that edge.
  - All channels idle with no stuck channel: raw=0, never counts.
  - One channel stuck while another is active (not idle, not stuck): raw=0.
- Single clock domain; no multicycle paths. state encoding is fixed as listed for visibility in waveforms.

Test Plan:
- Reset mid-qualification:
  - Stimulus: THRESHOLD=4, NUM_CH=2, enable=1; reset asserted, then axis_block_sigs=2'b01 and inst_idle_sigs=2'b10 held from edge 1.
  - Required: state 1 after edge 1; block=1, block_pulse=1, block_chan=2'b01, stall_cycles=4 after edge 4; block_pulse=0 after edge 5.
  - Stimulus: assert kernel_monitor_reset_n=0 asynchronously mid-SUSPECT.
  - Required: all outputs 0 immediately.
- Glitch rejection:
  - Stimulus: raw high for 3 edges, low 1 edge, high 3 edges with THRESHOLD=4.
  - Required: block never asserts; stall_cycles peaks at 3 and returns to 0 when raw is low.
- Active-channel veto:
  - Stimulus: axis_block_sigs=2'b01, inst_idle_sigs=2'b00, inst_block_sigs=0 held for 100 cycles.
  - Required: state stays 0, block=0.
- Sticky latch and saturation:
  - Stimulus: CNT_W=4, THRESHOLD=4; declare deadlock, then hold raw for 20 more edges, then drop raw.
  - Required: stall_cycles saturates at 15; block stays 1 after raw drops; block_chan unchanged.
- Clear priority:
  - Stimulus: in DEADLOCK, assert clear for 1 cycle while raw=1.
  - Required: state 0, block=0, block_chan=0, stall_cycles=0; requalification restarts, block re-asserts 4 edges later with a fresh single block_pulse.
- Enable gating:
  - Stimulus: enable=0 with raw=1 for 50 cycles.
  - Required: state 0.
  - Stimulus: raise enable.
  - Required: deadlock declared exactly THRESHOLD edges later.

Source files
------------

// File: rtl/axis_stall_watchdog.sv
// axis_stall_watchdog
// Qualifies a kernel deadlock: at least one channel must be stuck, and no
// channel may be doing work, for THRESHOLD consecutive sampled edges before
// a deadlock is declared. On declaration the stuck-channel vector is
// captured. The stall duration keeps counting (saturating) until a clear.
module axis_stall_watchdog #(
  parameter int NUM_CH    = 2,
  parameter int THRESHOLD = 16,
  parameter int CNT_W     = 16
) (
  input  logic              kernel_monitor_clock,
  input  logic              kernel_monitor_reset_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] axis_block_sigs,
  input  logic [NUM_CH-1:0] inst_block_sigs,
  input  logic [NUM_CH-1:0] inst_idle_sigs,
  output logic              block,
  output logic              block_pulse,
  output logic [NUM_CH-1:0] block_chan,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [1:0]        state
);

  // Encoding is fixed so the state reads the same in every waveform viewer.
  typedef enum logic [1:0] {
    WATCH    = 2'd0,
    SUSPECT  = 2'd1,
    DEADLOCK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESHOLD - 1);
  localparam logic [CNT_W-1:0] THRESH_V  = CNT_W'(THRESHOLD);

  state_t            cur_state;
  logic [NUM_CH-1:0] stuck;
  logic [NUM_CH-1:0] quiet;
  logic              raw;
  logic [CNT_W-1:0]  stall_inc;

  assign state = cur_state;

  // A channel is quiet when it is either stuck or idle. The stall condition
  // needs at least one stuck channel and no channel making progress.
  assign stuck = axis_block_sigs | inst_block_sigs;
  assign quiet = stuck | inst_idle_sigs;
  assign raw   = (|stuck) & (&quiet);

  // The stall counter saturates instead of wrapping, so a long episode never
  // reads back as a short one.
  assign stall_inc = (stall_cycles == CNT_MAX) ? stall_cycles : stall_cycles + CNT_ONE;

  // Qualification FSM. Clear overrides every state. DEADLOCK can only be
  // left through clear or reset.
  always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset_n) begin
    if (!kernel_monitor_reset_n) begin
      cur_state    <= WATCH;
      stall_cycles <= '0;
      block        <= 1'b0;
      block_pulse  <= 1'b0;
      block_chan   <= '0;
    end else if (clear) begin
      cur_state    <= WATCH;
      stall_cycles <= '0;
      block        <= 1'b0;
      block_pulse  <= 1'b0;
      block_chan   <= '0;
    end else begin
      block_pulse <= 1'b0;
      case (cur_state)
        WATCH: begin
          if (enable && raw) begin
            cur_state    <= SUSPECT;
            stall_cycles <= CNT_ONE;
          end else begin
            stall_cycles <= '0;
          end
        end
        SUSPECT: begin
          if (!enable || !raw) begin
            cur_state    <= WATCH;
            stall_cycles <= '0;
          end else if (stall_cycles == THRESH_M1) begin
            cur_state    <= DEADLOCK;
            stall_cycles <= THRESH_V;
            block        <= 1'b1;
            block_pulse  <= 1'b1;
            block_chan   <= stuck;
          end else begin
            stall_cycles <= stall_inc;
          end
        end
        DEADLOCK: begin
          if (raw) begin
            stall_cycles <= stall_inc;
          end
        end
        default: begin
          cur_state    <= WATCH;
          stall_cycles <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_stall_watchdog.sv
// tb_axis_stall_watchdog
// Directed vector bench for axis_stall_watchdog with THRESHOLD=4 and CNT_W=4.
// Each table record gives one edge of inputs together with the outputs
// expected just after that edge. A few hand-written sequences cover the
// asynchronous reset cases.
module tb_axis_stall_watchdog;

  localparam int NUM_CH    = 2;
  localparam int THRESHOLD = 4;
  localparam int CNT_W     = 4;

  typedef struct {
    string      name;
    logic       en;
    logic       clr;
    logic [1:0] ax;
    logic [1:0] ib;
    logic [1:0] id;
    logic       e_block;
    logic       e_pulse;
    logic [1:0] e_chan;
    logic [3:0] e_stall;
    logic [1:0] e_state;
  } vec_t;

  logic              kernel_monitor_clock;
  logic              kernel_monitor_reset_n;
  logic              enable;
  logic              clear;
  logic [NUM_CH-1:0] axis_block_sigs;
  logic [NUM_CH-1:0] inst_block_sigs;
  logic [NUM_CH-1:0] inst_idle_sigs;
  logic              block;
  logic              block_pulse;
  logic [NUM_CH-1:0] block_chan;
  logic [CNT_W-1:0]  stall_cycles;
  logic [1:0]        state;

  int   checks = 0;
  int   fails  = 0;
  vec_t vecs[$];

  axis_stall_watchdog #(
    .NUM_CH   (NUM_CH),
    .THRESHOLD(THRESHOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .kernel_monitor_clock  (kernel_monitor_clock),
    .kernel_monitor_reset_n(kernel_monitor_reset_n),
    .enable                (enable),
    .clear                 (clear),
    .axis_block_sigs       (axis_block_sigs),
    .inst_block_sigs       (inst_block_sigs),
    .inst_idle_sigs        (inst_idle_sigs),
    .block                 (block),
    .block_pulse           (block_pulse),
    .block_chan            (block_chan),
    .stall_cycles          (stall_cycles),
    .state                 (state)
  );

  // Free-running monitor clock, 10 time units per period.
  initial begin
    kernel_monitor_clock = 1'b0;
    forever #5 kernel_monitor_clock = ~kernel_monitor_clock;
  end

  // Appends one edge of stimulus together with its expected outputs.
  function automatic void add(string n, logic en, logic clr, logic [1:0] ax,
                              logic [1:0] ib, logic [1:0] id, logic eb, logic ep,
                              logic [1:0] ec, int es, int est);
    vec_t v;
    v.name    = n;
    v.en      = en;
    v.clr     = clr;
    v.ax      = ax;
    v.ib      = ib;
    v.id      = id;
    v.e_block = eb;
    v.e_pulse = ep;
    v.e_chan  = ec;
    v.e_stall = 4'(es);
    v.e_state = 2'(est);
    vecs.push_back(v);
  endfunction

  // Drives one set of inputs and lets the next rising edge sample them. It
  // returns 1 time unit after that edge, away from the clock.
  task automatic applyStimulus(input logic en, input logic clr, input logic [1:0] ax,
                               input logic [1:0] ib, input logic [1:0] id);
    enable          = en;
    clear           = clr;
    axis_block_sigs = ax;
    inst_block_sigs = ib;
    inst_idle_sigs  = id;
    @(posedge kernel_monitor_clock);
    #1;
  endtask

  task automatic checkOutput(input string n, input logic eb, input logic ep,
                             input logic [1:0] ec, input logic [3:0] es, input logic [1:0] est);
    checks++;
    if (block !== eb || block_pulse !== ep || block_chan !== ec ||
        stall_cycles !== es || state !== est) begin
      fails++;
      $display("[TB] FAIL %s: got block=%b pulse=%b chan=%b stall=%0d state=%0d, expected block=%b pulse=%b chan=%b stall=%0d state=%0d",
               n, block, block_pulse, block_chan, stall_cycles, state, eb, ep, ec, es, est);
    end
  endtask

  // Builds the vector table, applies it, then runs the reset sequences.
  initial begin
    kernel_monitor_reset_n = 1'b0;
    enable                 = 1'b0;
    clear                  = 1'b0;
    axis_block_sigs        = '0;
    inst_block_sigs        = '0;
    inst_idle_sigs         = '0;

    // Qualify through an AXIS port: ch0 blocked, ch1 idle, so raw=1.
    add("qual_e1", 1, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 1, 1);
    add("qual_e2", 1, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 2, 1);
    add("qual_e3", 1, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 3, 1);
    add("qual_e4", 1, 0, 2'b01, 2'b00, 2'b10, 1, 1, 2'b01, 4, 2);
    // Raw held after declaration: the count runs up and saturates at 15.
    for (int k = 1; k <= 20; k++)
      add("sat", 1, 0, 2'b01, 2'b00, 2'b10, 1, 0, 2'b01, (4 + k > 15) ? 15 : 4 + k, 2);
    // Raw dropped while enable is low: the latch stays and the count holds.
    for (int k = 0; k < 3; k++)
      add("sticky", 0, 0, 2'b00, 2'b00, 2'b10, 1, 0, 2'b01, 15, 2);
    // Clear while raw is high wins and zeroes everything.
    add("clr_dl", 1, 1, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 0, 0);
    // Requalification gives a fresh single pulse.
    add("req_e1", 1, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 1, 1);
    add("req_e2", 1, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 2, 1);
    add("req_e3", 1, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 3, 1);
    add("req_e4", 1, 0, 2'b01, 2'b00, 2'b10, 1, 1, 2'b01, 4, 2);
    add("req_e5", 0, 0, 2'b01, 2'b00, 2'b10, 1, 0, 2'b01, 5, 2);
    add("clr_q",  1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0);
    // Glitch: three high, one low, three high, one low. Never declares.
    add("gl_a1", 1, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 1, 1);
    add("gl_a2", 1, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 2, 1);
    add("gl_a3", 1, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 3, 1);
    add("gl_lo", 1, 0, 2'b00, 2'b00, 2'b10, 0, 0, 2'b00, 0, 0);
    add("gl_b1", 1, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 1, 1);
    add("gl_b2", 1, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 2, 1);
    add("gl_b3", 1, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 3, 1);
    add("gl_l2", 1, 0, 2'b00, 2'b00, 2'b10, 0, 0, 2'b00, 0, 0);
    // Qualify through an internal channel: inst1 blocked, inst0 idle.
    add("ib_e1", 1, 0, 2'b00, 2'b10, 2'b01, 0, 0, 2'b00, 1, 1);
    add("ib_e2", 1, 0, 2'b00, 2'b10, 2'b01, 0, 0, 2'b00, 2, 1);
    add("ib_e3", 1, 0, 2'b00, 2'b10, 2'b01, 0, 0, 2'b00, 3, 1);
    add("ib_e4", 1, 0, 2'b00, 2'b10, 2'b01, 1, 1, 2'b10, 4, 2);
    add("ib_clr", 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0);
    // Clear in SUSPECT, then raw on the first edge after clear starts again at 1.
    add("cs_e1",  1, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 1, 1);
    add("cs_e2",  1, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 2, 1);
    add("cs_clr", 1, 1, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 0, 0);
    add("cs_re1", 1, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 1, 1);
    add("cs_dis", 0, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 0, 0);
    // All idle with nothing stuck never counts.
    for (int k = 0; k < 3; k++)
      add("all_idle", 1, 0, 2'b00, 2'b00, 2'b11, 0, 0, 2'b00, 0, 0);
    // Enable low with raw high for 50 edges stays in WATCH.
    for (int k = 0; k < 50; k++)
      add("en_off", 0, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 0, 0);
    // Raising enable declares exactly THRESHOLD edges later.
    add("en_e1", 1, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 1, 1);
    add("en_e2", 1, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 2, 1);
    add("en_e3", 1, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 3, 1);
    add("en_e4", 1, 0, 2'b01, 2'b00, 2'b10, 1, 1, 2'b01, 4, 2);
    add("en_clr", 1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0);
    // One stuck channel with the other active vetoes the stall condition.
    for (int k = 0; k < 100; k++)
      add("veto", 1, 0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0);

    #3;
    checkOutput("reset_state", 0, 0, 2'b00, 4'd0, 2'd0);
    #9;
    kernel_monitor_reset_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].clr, vecs[i].ax, vecs[i].ib, vecs[i].id);
      checkOutput(vecs[i].name, vecs[i].e_block, vecs[i].e_pulse, vecs[i].e_chan,
                  vecs[i].e_stall, vecs[i].e_state);
    end

    // Asynchronous reset in the middle of SUSPECT clears outputs immediately.
    applyStimulus(1, 0, 2'b01, 2'b00, 2'b10);
    checkOutput("ar_e1", 0, 0, 2'b00, 4'd1, 2'd1);
    applyStimulus(1, 0, 2'b01, 2'b00, 2'b10);
    checkOutput("ar_e2", 0, 0, 2'b00, 4'd2, 2'd1);
    #2;
    kernel_monitor_reset_n = 1'b0;
    #1;
    checkOutput("ar_immediate", 0, 0, 2'b00, 4'd0, 2'd0);
    applyStimulus(1, 0, 2'b01, 2'b00, 2'b10);
    checkOutput("ar_held", 0, 0, 2'b00, 4'd0, 2'd0);
    kernel_monitor_reset_n = 1'b1;
    applyStimulus(1, 0, 2'b01, 2'b00, 2'b10);
    checkOutput("ar_rel_e1", 0, 0, 2'b00, 4'd1, 2'd1);
    applyStimulus(1, 0, 2'b01, 2'b00, 2'b10);
    applyStimulus(1, 0, 2'b01, 2'b00, 2'b10);
    applyStimulus(1, 0, 2'b01, 2'b00, 2'b10);
    checkOutput("ar_rel_e4", 1, 1, 2'b01, 4'd4, 2'd2);

    // Asynchronous reset in DEADLOCK also clears at once.
    #2;
    kernel_monitor_reset_n = 1'b0;
    #1;
    checkOutput("ar_deadlock", 0, 0, 2'b00, 4'd0, 2'd0);

    $display("[TB] %0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
